// File: rtl/snoop_bus_control.sv
// Snoop bus controller: round-robin arbitration of per-core misses, cache-to-cache forwarding and invalidation.
// Latency: ARB + SNOOP + one beat per block word; dwait stays high until each word is accepted, and memory stalls through mem_dwait.
module snoop_bus_control #(
    parameter int NCORES      = 2,
    parameter int BLOCK_WORDS = 2,
    parameter int WW          = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NCORES-1:0]     dREN,
    input  logic [NCORES-1:0]     dWEN,
    input  logic [NCORES-1:0]     ccwrite,
    input  logic [WW-1:0]         daddr       [NCORES],
    input  logic [WW-1:0]         dstore      [NCORES],
    output logic [NCORES-1:0]     dwait,
    output logic [WW-1:0]         dload       [NCORES],
    output logic [NCORES-1:0]     ccwait,
    output logic [NCORES-1:0]     ccinv,
    output logic [WW-1:0]         ccsnoopaddr [NCORES],
    output logic                  mem_dREN,
    output logic                  mem_dWEN,
    output logic [WW-1:0]         mem_daddr,
    output logic [WW-1:0]         mem_dstore,
    input  logic [WW-1:0]         mem_dload,
    input  logic                  mem_dwait
);

    localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int CW = $clog2(BLOCK_WORDS) + 1;

    typedef enum logic [2:0] {
        IDLE, ARB, SNOOP, MEM_WB, OWNER_WB, MEM_READ, UPGRADE
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   grant, grant_n;
    logic [PW-1:0]   owner, owner_n;
    logic            rdx, rdx_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [PW-1:0]   rr_ptr, rr_n;

    logic [NCORES-1:0] req;
    logic [PW-1:0]     arb_g, own_k, cur_g, nxt_rr;
    logic              arb_found, own_found, last;
    logic [NCORES-1:0] not_g;

    assign req    = dREN | dWEN | ccwrite;
    assign cur_g  = (state == ARB) ? arb_g : grant;
    assign last   = (cnt == CW'(BLOCK_WORDS - 1));
    assign nxt_rr = PW'((int'(grant) + 1) % NCORES);
    assign not_g  = ~(NCORES'(1) << grant);

    always_comb begin : search
        logic [PW-1:0] idx;
        idx       = '0;
        arb_found = 1'b0;
        arb_g     = '0;
        own_found = 1'b0;
        own_k     = '0;
        for (int i = 0; i < NCORES; i++) begin
            idx = PW'((int'(rr_ptr) + i) % NCORES);
            if (!arb_found && req[idx]) begin
                arb_found = 1'b1;
                arb_g     = idx;
            end
        end
        // Lowest-index Modified holder other than the requester supplies the block.
        for (int k = 0; k < NCORES; k++) begin
            if (!own_found && (k != int'(grant)) && ccwrite[k]) begin
                own_found = 1'b1;
                own_k     = PW'(k);
            end
        end
    end

    always_comb begin : fsm
        state_n    = state;
        grant_n    = grant;
        owner_n    = owner;
        rdx_n      = rdx;
        cnt_n      = cnt;
        rr_n       = rr_ptr;
        dwait      = '1;
        ccinv      = '0;
        ccwait     = '0;
        mem_dREN   = 1'b0;
        mem_dWEN   = 1'b0;
        mem_daddr  = '0;
        mem_dstore = '0;
        for (int i = 0; i < NCORES; i++) begin
            dload[i]       = '0;
            ccsnoopaddr[i] = '0;
        end

        if (state != IDLE) begin
            ccwait = ~(NCORES'(1) << cur_g);
            for (int i = 0; i < NCORES; i++) ccsnoopaddr[i] = daddr[cur_g];
        end

        case (state)
            IDLE: if (|req) state_n = ARB;
            ARB: begin
                if (!arb_found) begin
                    state_n = IDLE;
                end else begin
                    grant_n = arb_g;
                    rdx_n   = dREN[arb_g] & ccwrite[arb_g];
                    if (dWEN[arb_g])                          state_n = MEM_WB;
                    else if (ccwrite[arb_g] && !dREN[arb_g])  state_n = UPGRADE;
                    else                                      state_n = SNOOP;
                end
            end
            SNOOP: begin
                owner_n = own_k;
                state_n = own_found ? OWNER_WB : MEM_READ;
            end
            MEM_WB: begin
                mem_dWEN   = 1'b1;
                mem_daddr  = daddr[grant];
                mem_dstore = dstore[grant];
                if (!mem_dwait) dwait[grant] = 1'b0;
            end
            OWNER_WB: begin
                mem_dWEN   = 1'b1;
                mem_daddr  = daddr[grant];
                mem_dstore = dstore[owner];
                if (!mem_dwait) begin
                    dwait[owner] = 1'b0;
                    dwait[grant] = 1'b0;
                    dload[grant] = dstore[owner];
                    if (last && rdx) ccinv = not_g;
                end
            end
            MEM_READ: begin
                mem_dREN  = 1'b1;
                mem_daddr = daddr[grant];
                if (!mem_dwait) begin
                    dwait[grant] = 1'b0;
                    dload[grant] = mem_dload;
                    if (last && rdx) ccinv = not_g;
                end
            end
            UPGRADE: begin
                ccinv        = not_g;
                dwait[grant] = 1'b0;
                rr_n         = nxt_rr;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if ((state == MEM_WB || state == OWNER_WB || state == MEM_READ) && !mem_dwait) begin
            if (last) begin
                cnt_n   = '0;
                rr_n    = nxt_rr;
                state_n = IDLE;
            end else begin
                cnt_n = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            grant  <= '0;
            owner  <= '0;
            rdx    <= 1'b0;
            cnt    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            owner  <= owner_n;
            rdx    <= rdx_n;
            cnt    <= cnt_n;
            rr_ptr <= rr_n;
        end
    end

endmodule
